// File: rtl/inst_wb_master.sv
// rtl/inst_wb_master.sv - read-only Wishbone classic master for instruction fetch
module inst_wb_master #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_err_o,
    output logic        stallreq_o,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   rd_buf_q, rd_buf_d;
    logic          err_buf_q, err_buf_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic          bus_err;
    logic          bus_tmo;
    logic          fetch_stalled;
    logic          unused_stall;

    // Only the fetch-stage bit of the stall vector matters here.
    assign fetch_stalled = stall_i[1];
    assign unused_stall  = ^{stall_i[5:2], stall_i[0]};

    // Ack wins over err; timeout only counts when the slave is silent.
    assign bus_err = wb_err_i & ~wb_ack_i;
    assign bus_tmo = (tcnt_q == TW'(TIMEOUT - 1)) & ~wb_ack_i & ~wb_err_i;

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = 1'b0;
    assign wb_dat_o = 32'h0;

    // State and bus register update with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            adr_q     <= 32'h0;
            sel_q     <= 4'h0;
            rd_buf_q  <= 32'h0;
            err_buf_q <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            rd_buf_q  <= rd_buf_d;
            err_buf_q <= err_buf_d;
            tcnt_q    <= tcnt_d;
        end
    end

    // Next-state logic and the combinational CPU-side outputs.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        rd_buf_d   = rd_buf_q;
        err_buf_d  = err_buf_q;
        tcnt_d     = tcnt_q;
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;
        cpu_err_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    stallreq_o = 1'b1;
                    state_d    = S_BUSY;
                    cyc_d      = 1'b1;
                    adr_d      = cpu_addr_i;
                    sel_d      = 4'hF;
                    tcnt_d     = '0;
                end
            end
            S_BUSY: begin
                if (wb_ack_i) begin
                    cpu_data_o = wb_dat_i;
                end
                cpu_err_o  = bus_err | bus_tmo;
                stallreq_o = ~(wb_ack_i | wb_err_i | bus_tmo);
                if (flush_i) begin
                    // Flushed fetch: drop the cycle and swallow any late ack in DRAIN.
                    state_d   = S_DRAIN;
                    cyc_d     = 1'b0;
                    sel_d     = 4'h0;
                    rd_buf_d  = 32'h0;
                    err_buf_d = 1'b0;
                end else if (wb_ack_i || wb_err_i || bus_tmo) begin
                    cyc_d     = 1'b0;
                    sel_d     = 4'h0;
                    rd_buf_d  = wb_ack_i ? wb_dat_i : 32'h0;
                    err_buf_d = bus_err | bus_tmo;
                    if (bus_tmo) begin
                        state_d = S_DRAIN;
                    end else if (fetch_stalled) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                cpu_data_o = rd_buf_q;
                cpu_err_o  = err_buf_q;
                if (!fetch_stalled || flush_i) begin
                    state_d   = S_IDLE;
                    rd_buf_d  = 32'h0;
                    err_buf_d = 1'b0;
                end
            end
            S_DRAIN: begin
                stallreq_o = cpu_ce_i;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wb_rst_i) begin
            stallreq_o = 1'b0;
            cpu_data_o = 32'h0;
            cpu_err_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_wb_master.sv
// tb/tb_inst_wb_master.sv - self-checking bench for inst_wb_master
module tb_inst_wb_master;

    localparam int TIMEOUT = 16;
    localparam int TW      = 5;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce;
    logic [31:0] cpu_addr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] cpu_data;
    logic        cpu_err;
    logic        stallreq;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_wb_master #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cpu_ce_i   (cpu_ce),
        .cpu_addr_i (cpu_addr),
        .stall_i    (stall),
        .flush_i    (flush),
        .cpu_data_o (cpu_data),
        .cpu_err_o  (cpu_err),
        .stallreq_o (stallreq),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel),
        .wb_we_o    (wb_we),
        .wb_stb_o   (wb_stb),
        .wb_cyc_o   (wb_cyc),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        return {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    endfunction

    // One fetch seen from the CPU side. Expected behaviour is derived from the
    // transaction description: lat = stb cycles until the slave responds,
    // kind = response type, hold = cycles the fetch stage stays stalled after it.
    task automatic do_fetch(input logic [31:0] addr, input int lat, input int kind,
                            input logic [31:0] data, input int hold, input string tag);
        int          n_wait;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        ce_r;
        n_wait   = (kind == K_NONE) ? TIMEOUT - 1 : lat - 1;
        exp_data = (kind == K_ACK || kind == K_BOTH) ? data : 32'h0;
        exp_err  = (kind == K_ERR || kind == K_NONE);

        cpu_ce = 1'b1; cpu_addr = addr; flush = 1'b0; stall = 6'b0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom;
        smp();
        checks++;
        if ({wb_cyc, wb_stb, stallreq} !== 3'b001) begin
            failures++;
            $display("FAIL %s req cyc/stb/stallreq=%b expected 001", tag, {wb_cyc, wb_stb, stallreq});
        end
        tick();

        for (int i = 0; i < n_wait; i++) begin
            wb_dat_i = $urandom;
            smp();
            checks++;
            if ({wb_cyc, wb_stb, wb_sel, wb_we, stallreq, cpu_err} !== 9'b11_1111_0_1_0 ||
                wb_adr !== addr || cpu_data !== 32'h0) begin
                failures++;
                $display("FAIL %s wait%0d cyc/stb/sel/we/stall/err=%b adr=%h data=%h expected 111111010 adr=%h data=0",
                         tag, i, {wb_cyc, wb_stb, wb_sel, wb_we, stallreq, cpu_err}, wb_adr, cpu_data, addr);
            end
            tick();
        end

        wb_ack   = (kind == K_ACK || kind == K_BOTH);
        wb_err   = (kind == K_ERR || kind == K_BOTH);
        wb_dat_i = data;
        stall    = (hold > 0) ? 6'b000011 : 6'b000000;
        smp();
        checks++;
        if (stallreq !== 1'b0 || cpu_data !== exp_data || cpu_err !== exp_err || wb_cyc !== 1'b1) begin
            failures++;
            $display("FAIL %s resp stallreq=%b data=%h err=%b cyc=%b expected 0 %h %b 1",
                     tag, stallreq, cpu_data, cpu_err, wb_cyc, exp_data, exp_err);
        end
        tick();
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom; cpu_ce = 1'b0;

        if (kind == K_NONE) begin
            ce_r = 1'($urandom_range(0, 1));
            cpu_ce = ce_r; wb_ack = 1'($urandom_range(0, 1));
            smp();
            checks++;
            if (wb_cyc !== 1'b0 || stallreq !== ce_r || cpu_data !== 32'h0 || cpu_err !== 1'b0) begin
                failures++;
                $display("FAIL %s drain cyc=%b stallreq=%b data=%h err=%b expected 0 %b 0 0",
                         tag, wb_cyc, stallreq, cpu_data, cpu_err, ce_r);
            end
            tick();
            wb_ack = 1'b0; cpu_ce = 1'b0;
        end else begin
            for (int k = 1; k <= hold; k++) begin
                stall  = (k < hold) ? 6'b000011 : 6'b000000;
                cpu_ce = 1'($urandom_range(0, 1));
                wb_dat_i = $urandom;
                smp();
                checks++;
                if (wb_cyc !== 1'b0 || stallreq !== 1'b0 || cpu_data !== exp_data || cpu_err !== exp_err) begin
                    failures++;
                    $display("FAIL %s hold%0d cyc=%b stallreq=%b data=%h err=%b expected 0 0 %h %b",
                             tag, k, wb_cyc, stallreq, cpu_data, cpu_err, exp_data, exp_err);
                end
                tick();
            end
            cpu_ce = 1'b0; stall = 6'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_ce = 1'b1; cpu_addr = 32'h0000_0040; stall = 6'b0; flush = 1'b0;
        wb_ack = 1'b1; wb_err = 1'b0; wb_dat_i = 32'hDEAD_BEEF;
        tick(); tick();
        smp();
        checks++;
        if ({wb_cyc, wb_stb, wb_sel, wb_we, stallreq, cpu_err} !== 9'b0 ||
            wb_adr !== 32'h0 || wb_dat_o !== 32'h0 || cpu_data !== 32'h0) begin
            failures++;
            $display("FAIL reset ctl=%b adr=%h dat_o=%h data=%h expected all zero",
                     {wb_cyc, wb_stb, wb_sel, wb_we, stallreq, cpu_err}, wb_adr, wb_dat_o, cpu_data);
        end
        tick();
        rst = 1'b0; cpu_ce = 1'b0; wb_ack = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        do_fetch(32'h0000_0010, 1, K_ACK, 32'h0000_0513, 0, "single");
    endtask

    task automatic test_stall_hold();
        do_fetch(32'h0000_0010, 1, K_ACK, 32'h0000_0513, 4, "hold");
        smp();
        checks++;
        if (wb_cyc !== 1'b0 || cpu_data !== 32'h0 || stallreq !== 1'b0) begin
            failures++;
            $display("FAIL hold_exit cyc=%b data=%h stallreq=%b expected 0 0 0", wb_cyc, cpu_data, stallreq);
        end
        tick();
    endtask

    task automatic test_bus_error();
        do_fetch(32'h0000_0100, 1, K_ERR, 32'h1234_5678, 0, "err");
        do_fetch(32'h0000_0104, 3, K_ERR, 32'h1234_5678, 2, "err_hold");
        do_fetch(32'h0000_0108, 2, K_BOTH, 32'hCAFE_0001, 1, "ack_err");
    endtask

    task automatic test_timeout();
        do_fetch(32'h0000_0200, 0, K_NONE, 32'h0, 0, "timeout");
        do_fetch(32'h0000_0204, TIMEOUT, K_ACK, 32'h0BAD_F00D, 0, "ack_at_limit");
        do_fetch(32'h0000_0208, 0, K_NONE, 32'h0, 2, "timeout_stalled");
    endtask

    task automatic test_flush();
        cpu_ce = 1'b1; cpu_addr = 32'h0000_0010; flush = 1'b0; stall = 6'b0;
        tick();
        smp();
        checks++;
        if (wb_cyc !== 1'b1 || wb_adr !== 32'h10) begin
            failures++;
            $display("FAIL flush_stb cyc=%b adr=%h expected 1 00000010", wb_cyc, wb_adr);
        end
        tick();
        flush = 1'b1;
        smp();
        checks++;
        if (stallreq !== 1'b1 || cpu_data !== 32'h0) begin
            failures++;
            $display("FAIL flush_busy stallreq=%b data=%h expected 1 0", stallreq, cpu_data);
        end
        tick();
        flush = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h0000_0513; cpu_addr = 32'h0000_0020;
        smp();
        checks++;
        if (wb_cyc !== 1'b0 || cpu_data !== 32'h0 || cpu_err !== 1'b0 || stallreq !== 1'b1) begin
            failures++;
            $display("FAIL flush_drain cyc=%b data=%h err=%b stallreq=%b expected 0 0 0 1",
                     wb_cyc, cpu_data, cpu_err, stallreq);
        end
        tick();
        wb_ack = 1'b0;
        do_fetch(32'h0000_0020, 1, K_ACK, 32'h0000_0093, 0, "after_flush");

        // Flush arriving together with the ack discards the data and never holds.
        cpu_ce = 1'b1; cpu_addr = 32'h0000_0030;
        tick();
        cpu_ce = 1'b0; flush = 1'b1; wb_ack = 1'b1; stall = 6'b000010; wb_dat_i = 32'h7777_0001;
        tick();
        flush = 1'b0; wb_ack = 1'b0;
        smp();
        checks++;
        if (wb_cyc !== 1'b0 || cpu_data !== 32'h0 || cpu_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_ack cyc=%b data=%h err=%b expected 0 0 0", wb_cyc, cpu_data, cpu_err);
        end
        tick();
        stall = 6'b0;

        // Flush while holding a fetched word releases the hold.
        do_fetch(32'h0000_0040, 2, K_ACK, 32'h5555_AAAA, 3, "pre_hflush");
        cpu_ce = 1'b1; cpu_addr = 32'h0000_0044;
        tick();
        cpu_ce = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h1111_2222; stall = 6'b000010;
        tick();
        wb_ack = 1'b0; flush = 1'b1;
        smp();
        checks++;
        if (cpu_data !== 32'h1111_2222) begin
            failures++;
            $display("FAIL hflush_hold data=%h expected 11112222", cpu_data);
        end
        tick();
        flush = 1'b0;
        smp();
        checks++;
        if (cpu_data !== 32'h0 || wb_cyc !== 1'b0 || stallreq !== 1'b0) begin
            failures++;
            $display("FAIL hflush_idle data=%h cyc=%b stallreq=%b expected 0 0 0", cpu_data, wb_cyc, stallreq);
        end
        tick();
        stall = 6'b0;
    endtask

    task automatic test_idle_flush();
        cpu_ce = 1'b1; cpu_addr = 32'h0000_0050; flush = 1'b1;
        smp();
        checks++;
        if (stallreq !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush stallreq=%b expected 0", stallreq);
        end
        tick();
        cpu_ce = 1'b0; flush = 1'b0;
        smp();
        checks++;
        if (wb_cyc !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush_cyc cyc=%b expected 0", wb_cyc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        cpu_ce = 1'b1; cpu_addr = 32'h0000_0060;
        tick();
        rst = 1'b1; wb_ack = 1'b1; wb_dat_i = 32'h4444_5555;
        smp();
        checks++;
        if (stallreq !== 1'b0 || cpu_data !== 32'h0 || cpu_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_comb stallreq=%b data=%h err=%b expected 0 0 0", stallreq, cpu_data, cpu_err);
        end
        tick();
        rst = 1'b0; wb_ack = 1'b0; cpu_ce = 1'b0;
        smp();
        checks++;
        if ({wb_cyc, wb_stb, wb_sel, stallreq} !== 7'b0 || wb_adr !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid cyc/stb/sel/stall=%b adr=%h expected 0 0",
                     {wb_cyc, wb_stb, wb_sel, stallreq}, wb_adr);
        end
        tick();
        do_fetch(32'h0000_0064, 1, K_ACK, 32'h0000_0013, 0, "after_rst");
    endtask

    task automatic test_random();
        int kind;
        int sel;
        for (int n = 0; n < 40; n++) begin
            sel  = $urandom_range(0, 9);
            kind = (sel < 6) ? K_ACK : (sel < 8) ? K_ERR : (sel < 9) ? K_BOTH : K_NONE;
            do_fetch(rand_addr(), $urandom_range(1, TIMEOUT), kind, $urandom,
                     $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_ce = 1'b0; cpu_addr = 32'h0; stall = 6'b0; flush = 1'b0;
        wb_dat_i = 32'h0; wb_ack = 1'b0; wb_err = 1'b0;
        test_reset();
        test_single_fetch();
        test_stall_hold();
        test_bus_error();
        test_timeout();
        test_flush();
        test_idle_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
